// File: rtl/dly_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : dly_glitch_filter
//  Description : Synchronizes a delay-chain output and qualifies level changes
//                over THR consecutive stable samples; counts aborted attempts.
//  Revision    : 1.0 - initial release
// ============================================================================
module dly_glitch_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             I,
  input  logic             EN,
  input  logic [CNT_W-1:0] THR,
  input  logic             CLR,
  output logic             Z,
  output logic             RISE,
  output logic             FALL,
  output logic             GLITCH,
  output logic [7:0]       GCNT
);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_QUALIFY = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   z_q, z_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   glitch_q, glitch_d;
  logic [7:0]             gcnt_q, gcnt_d;

  logic                   w_s;
  logic [CNT_W-1:0]       w_thr_eff;
  logic [CNT_W:0]         w_cnt_inc;
  logic                   w_qualified;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], I};
    w_s         = sync_q[SYNC_STAGES-1];
    w_thr_eff   = (THR == '0) ? CNT_W'(1) : THR;
    // One extra bit so the increment-and-compare can never wrap.
    w_cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    w_qualified = (w_cnt_inc >= {1'b0, w_thr_eff});
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    if (!EN) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (w_s != z_q) begin
            if (w_thr_eff == CNT_W'(1)) begin
              z_d    = w_s;
              rise_d = w_s;
              fall_d = ~w_s;
            end else begin
              state_d = ST_QUALIFY;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_QUALIFY: begin
          if (w_s == z_q) begin
            glitch_d = 1'b1;
            state_d  = ST_STABLE;
            cnt_d    = '0;
          end else if (w_qualified) begin
            z_d     = w_s;
            rise_d  = w_s;
            fall_d  = ~w_s;
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = w_cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle glitch increment.
  always_comb begin
    gcnt_d = gcnt_q;
    if (CLR) begin
      gcnt_d = '0;
    end else if (glitch_d && (gcnt_q != 8'hFF)) begin
      gcnt_d = gcnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q   <= {SYNC_STAGES{RST_VAL}};
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      z_q      <= RST_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      gcnt_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
      gcnt_q   <= gcnt_d;
    end
  end

  assign Z      = z_q;
  assign RISE   = rise_q;
  assign FALL   = fall_q;
  assign GLITCH = glitch_q;
  assign GCNT   = gcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dly_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dly_glitch_filter
//  Description : Directed scoreboard bench for dly_glitch_filter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dly_glitch_filter;

  localparam logic [2:0] K_RISE   = 3'b100;
  localparam logic [2:0] K_FALL   = 3'b010;
  localparam logic [2:0] K_GLITCH = 3'b001;

  logic       CLK = 1'b0;
  logic       RN  = 1'b0;
  logic       I   = 1'b0;
  logic       EN  = 1'b1;
  logic [3:0] THR = 4'd3;
  logic       CLR = 1'b0;
  logic       Z, RISE, FALL, GLITCH;
  logic [7:0] GCNT;

  dly_glitch_filter #(.SYNC_STAGES(2), .CNT_W(4), .RST_VAL(1'b0)) dut (
    .CLK(CLK), .RN(RN), .I(I), .EN(EN), .THR(THR), .CLR(CLR),
    .Z(Z), .RISE(RISE), .FALL(FALL), .GLITCH(GLITCH), .GCNT(GCNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] kind;
    logic       z;
    logic [7:0] gcnt;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  cyc    = 0;
  int  n_vec  = 0;
  int  n_err  = 0;
  int  g_exp  = 0;
  int  base;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge CLK) begin
    if (RN === 1'b1 && (RISE || FALL || GLITCH)) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_pulse: got rise/fall/glitch=%b z=%b gcnt=%0d at cycle %0d, expected no pulse",
                 {RISE, FALL, GLITCH}, Z, GCNT, cyc);
      end else begin
        mon_e = sb.pop_front();
        if ({RISE, FALL, GLITCH} !== mon_e.kind || Z !== mon_e.z ||
            GCNT !== mon_e.gcnt || cyc != mon_e.cyc) begin
          n_err++;
          $display("FAIL event: got kind=%b z=%b gcnt=%0d cycle=%0d, expected kind=%b z=%b gcnt=%0d cycle=%0d",
                   {RISE, FALL, GLITCH}, Z, GCNT, cyc,
                   mon_e.kind, mon_e.z, mon_e.gcnt, mon_e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic zz, input int at);
    ev_t e;
    e.kind = k;
    e.z    = zz;
    e.gcnt = g_exp[7:0];
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Level change on I, held; lat = edges from capture to Z update.
  task automatic level(input logic v, input logic [3:0] thr, input int lat);
    THR  = thr;
    I    = v;
    base = cyc;
    push(v ? K_RISE : K_FALL, v, base + lat);
    step(lat + 3);
  endtask

  // I high for w samples with Z=0, THR=4; optional CLR on the deciding edge.
  task automatic glitch(input int w, input logic clr);
    THR  = 4'd4;
    g_exp = clr ? 0 : ((g_exp < 255) ? g_exp + 1 : 255);
    base = cyc;
    push(K_GLITCH, 1'b0, base + w + 3);
    I = 1'b1;
    step(w);
    I = 1'b0;
    step(2);
    CLR = clr;
    step(1);
    CLR = 1'b0;
    step(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    step(2);
    chk("reset_z", {7'd0, Z}, 8'd0);
    chk("reset_gcnt", GCNT, 8'd0);
    chk("reset_pulses", {5'd0, RISE, FALL, GLITCH}, 8'd0);
    RN = 1'b1;
    step(3);

    level(1'b1, 4'd3, 5);
    chk("rise_thr3_z", {7'd0, Z}, 8'd1);
    chk("rise_thr3_gcnt", GCNT, 8'd0);
    level(1'b0, 4'd1, 3);
    level(1'b1, 4'd1, 3);
    level(1'b0, 4'd0, 3);
    chk("thr0_fall_z", {7'd0, Z}, 8'd0);

    glitch(2, 1'b0);
    chk("glitch_once_z", {7'd0, Z}, 8'd0);
    chk("glitch_once_gcnt", GCNT, 8'd1);
    for (int k = 0; k < 299; k++) glitch(2, 1'b0);
    chk("glitch_sat_gcnt", GCNT, 8'd255);
    chk("glitch_sat_z", {7'd0, Z}, 8'd0);

    CLR = 1'b1;
    step(1);
    CLR = 1'b0;
    g_exp = 0;
    chk("clr_gcnt", GCNT, 8'd0);
    glitch(2, 1'b0);
    glitch(2, 1'b1);
    chk("clr_vs_glitch_gcnt", GCNT, 8'd0);

    THR  = 4'd8;
    I    = 1'b1;
    base = cyc;
    push(K_RISE, 1'b1, base + 8);
    step(7);
    THR = 4'd2;
    step(4);
    chk("thr_lowered_z", {7'd0, Z}, 8'd1);

    level(1'b0, 4'd1, 3);
    EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      I = ~I;
      step(1);
    end
    I = 1'b1;
    step(4);
    chk("en0_z_hold", {7'd0, Z}, 8'd0);
    chk("en0_gcnt_hold", GCNT, g_exp[7:0]);
    EN   = 1'b1;
    THR  = 4'd2;
    base = cyc;
    push(K_RISE, 1'b1, base + 2);
    step(5);
    chk("en1_rise_z", {7'd0, Z}, 8'd1);

    THR = 4'd6;
    I   = 1'b0;
    step(5);
    RN = 1'b0;
    #1;
    chk("async_reset_z", {7'd0, Z}, 8'd0);
    chk("async_reset_gcnt", GCNT, 8'd0);
    chk("async_reset_pulses", {5'd0, RISE, FALL, GLITCH}, 8'd0);
    g_exp = 0;
    step(2);
    RN = 1'b1;
    step(10);
    chk("post_reset_z", {7'd0, Z}, 8'd0);

    step(3);
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_event: got no pulse, expected kind=%b z=%b gcnt=%0d cycle=%0d",
               mon_e.kind, mon_e.z, mon_e.gcnt, mon_e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
